load_store_unit: RTL and testbench

//  Initiator side of the data-memory port. Accepts one load/store request from the execute stage.

---
 rtl/lsu_pkg.sv | 40 ++++
 rtl/lsu_load_extend.sv | 22 ++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 values, error codes, FSM states, request payload.
package lsu_pkg;

    localparam int unsigned XLEN = 32;

    // Load funct3 encodings
    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;

    // Store funct3 encodings
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    // Response error codes
    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_MISALIGNED = 3'd1;
    localparam logic [2:0] ERR_RANGE      = 3'd2;
    localparam logic [2:0] ERR_ILLEGAL    = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    // Request fields captured at accept
    typedef struct packed {
        logic            is_store;
        logic [2:0]      funct3;
        logic [XLEN-1:0] ea;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

endpackage

// File: rtl/lsu_load_extend.sv
// Sign/zero extension of the captured memory word according to the load funct3.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] raw_data,
    output logic [XLEN-1:0] ext_data_c
);

    // Select the extension from the low byte/half of the captured word
    always_comb begin
        ext_data_c = raw_data;
        case (funct3)
            FUNCT3_LB:  ext_data_c = {{24{raw_data[7]}},  raw_data[7:0]};
            FUNCT3_LH:  ext_data_c = {{16{raw_data[15]}}, raw_data[15:0]};
            FUNCT3_LBU: ext_data_c = {24'd0, raw_data[7:0]};
            FUNCT3_LHU: ext_data_c = {16'd0, raw_data[15:0]};
            default:    ext_data_c = raw_data;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request, checks it, strobes data memory once and returns the result.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned MEM_BYTES      = 4096,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_base,
    input  logic [31:0] req_offset,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic [2:0]  resp_err,
    output logic [31:0] resp_addr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [2:0]  load_type,
    output logic [2:0]  store_type,
    output logic [31:0] ram_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e      state_q, state_d;
    lsu_req_t        req_q, req_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]      resp_err_q, resp_err_d;
    logic [31:0]     resp_rdata_q, resp_rdata_d;
    logic            req_ready_q, req_ready_d;
    logic            resp_valid_q, resp_valid_d;
    logic            mem_read_en_q, mem_read_en_d;
    logic            mem_write_en_q, mem_write_en_d;
    logic [2:0]      load_type_q, load_type_d;
    logic [2:0]      store_type_q, store_type_d;

    logic [31:0]     ea_c;
    logic            illegal_c;
    logic            misaligned_c;
    logic            range_c;
    logic [2:0]      chk_err_c;
    logic [31:0]     ext_data_c;

    // Effective address and request checks, priority illegal > misaligned > range
    always_comb begin
        ea_c = req_base + req_offset;
        if (req_is_store) begin
            illegal_c = (req_funct3 > FUNCT3_SW);
        end else begin
            illegal_c = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        misaligned_c = ((req_funct3[1:0] == 2'b01) && ea_c[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
        range_c      = (ea_c >= 32'(MEM_BYTES));
        chk_err_c    = ERR_NONE;
        if (illegal_c) begin
            chk_err_c = ERR_ILLEGAL;
        end else if (misaligned_c) begin
            chk_err_c = ERR_MISALIGNED;
        end else if (range_c) begin
            chk_err_c = ERR_RANGE;
        end
    end

    // Extension is applied to whatever the memory presents; only used when WAIT captures it
    lsu_load_extend u_load_extend (
        .funct3     (req_q.funct3),
        .raw_data   (mem_rdata),
        .ext_data_c (ext_data_c)
    );

    // Next-state logic and the next value of every registered output
    always_comb begin
        state_d      = state_q;
        req_d        = req_q;
        cnt_d        = cnt_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    req_d.is_store = req_is_store;
                    req_d.funct3   = req_funct3;
                    req_d.ea       = ea_c;
                    req_d.wdata    = req_wdata;
                    resp_rdata_d   = '0;
                    resp_err_d     = chk_err_c;
                    state_d        = (chk_err_c == ERR_NONE) ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                cnt_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_busy) begin
                    resp_rdata_d = req_q.is_store ? 32'd0 : ext_data_c;
                    state_d      = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                        resp_err_d = ERR_TIMEOUT;
                        state_d    = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs depend only on the upcoming state and latched request
        req_ready_d    = (state_d == ST_IDLE);
        resp_valid_d   = (state_d == ST_RESP);
        mem_read_en_d  = (state_d == ST_ISSUE) && !req_d.is_store;
        mem_write_en_d = (state_d == ST_ISSUE) &&  req_d.is_store;
        load_type_d    = mem_read_en_d  ? req_d.funct3 : 3'd0;
        store_type_d   = mem_write_en_d ? req_d.funct3 : 3'd0;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            req_q          <= '0;
            cnt_q          <= '0;
            resp_err_q     <= ERR_NONE;
            resp_rdata_q   <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_write_en_q <= 1'b0;
            load_type_q    <= 3'd0;
            store_type_q   <= 3'd0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            cnt_q          <= cnt_d;
            resp_err_q     <= resp_err_d;
            resp_rdata_q   <= resp_rdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_write_en_q <= mem_write_en_d;
            load_type_q    <= load_type_d;
            store_type_q   <= store_type_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_err     = resp_err_q;
    assign resp_addr    = req_q.ea;
    assign mem_read_en  = mem_read_en_q;
    assign mem_write_en = mem_write_en_q;
    assign load_type    = load_type_q;
    assign store_type   = store_type_q;
    assign ram_address  = req_q.ea;
    assign mem_wdata    = req_q.wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a small byte-addressed memory responder.
module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base;
    logic [31:0] req_offset;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [2:0]  resp_err;
    logic [31:0] resp_addr;
    logic        mem_read_en;
    logic        mem_write_en;
    logic [2:0]  load_type;
    logic [2:0]  store_type;
    logic [31:0] ram_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_busy;

    load_store_unit #(.MEM_BYTES(4096), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_store (req_is_store),
        .req_funct3   (req_funct3),
        .req_base     (req_base),
        .req_offset   (req_offset),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .resp_addr    (resp_addr),
        .mem_read_en  (mem_read_en),
        .mem_write_en (mem_write_en),
        .load_type    (load_type),
        .store_type   (store_type),
        .ram_address  (ram_address),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_busy     (mem_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] rdata;
        logic [2:0]  err;
        logic [31:0] addr;
        int          lat;
        int          strobe;   // 0 none, 1 read, 2 write
        logic [2:0]  ftype;
        int          acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_resp_cyc = 0;
    int   acc_cyc = 0;
    logic mem_dead = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Memory responder: reloads its image on reset, answers each strobe with a one-cycle mem_busy
    logic [7:0]  mem [0:4095];
    wire  [11:0] ma = ram_address[11:0];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
            mem[12'h104] <= 8'hEF; mem[12'h105] <= 8'hBE;
            mem[12'h106] <= 8'hAD; mem[12'h107] <= 8'hDE;
            mem[12'h004] <= 8'h44; mem[12'h005] <= 8'h33;
            mem[12'h006] <= 8'h22; mem[12'h007] <= 8'h11;
            mem_busy  <= 1'b0;
            mem_rdata <= 32'd0;
        end else begin
            mem_busy <= 1'b0;
            if (!mem_dead && mem_read_en) begin
                mem_busy  <= 1'b1;
                mem_rdata <= {mem[ma + 12'd3], mem[ma + 12'd2], mem[ma + 12'd1], mem[ma]};
            end
            if (!mem_dead && mem_write_en) begin
                mem_busy <= 1'b1;
                mem[ma] <= mem_wdata[7:0];
                if (store_type != 3'b000) mem[ma + 12'd1] <= mem_wdata[15:8];
                if (store_type == 3'b010) begin
                    mem[ma + 12'd2] <= mem_wdata[23:16];
                    mem[ma + 12'd3] <= mem_wdata[31:24];
                end
            end
        end
    end

    // Monitor: counts strobes per request and checks each response against the scoreboard
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    int         strobe_cyc = 0;
    logic [2:0] strobe_type = 3'd0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_cnt = 0;
                wr_cnt = 0;
            end else begin
                if (mem_read_en)  begin rd_cnt++; strobe_cyc = cyc; strobe_type = load_type;  end
                if (mem_write_en) begin wr_cnt++; strobe_cyc = cyc; strobe_type = store_type; end
                if (resp_valid) begin
                    if (sb_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_resp: got resp_valid at cycle %0d expected none", cyc);
                    end else begin
                        e = sb_q.pop_front();
                        chk({e.name, "_rdata"}, resp_rdata, e.rdata);
                        chk({e.name, "_err"}, 32'(resp_err), 32'(e.err));
                        chk({e.name, "_addr"}, resp_addr, e.addr);
                        chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(e.lat));
                        chk({e.name, "_rd_strobes"}, 32'(rd_cnt), (e.strobe == 1) ? 32'd1 : 32'd0);
                        chk({e.name, "_wr_strobes"}, 32'(wr_cnt), (e.strobe == 2) ? 32'd1 : 32'd0);
                        if (e.strobe != 0) begin
                            chk({e.name, "_strobe_cycle"}, 32'(strobe_cyc - e.acc), 32'd1);
                            chk({e.name, "_strobe_type"}, 32'(strobe_type), 32'(e.ftype));
                        end
                    end
                    last_resp_cyc = cyc;
                    rd_cnt = 0;
                    wr_cnt = 0;
                end
            end
        end
    end

    // Present one request, wait (bounded) for accept, optionally push its expected response
    task automatic issue(input string name, input logic st, input logic [2:0] f3,
                         input logic [31:0] base, input logic [31:0] off, input logic [31:0] wd,
                         input logic [31:0] x_rdata, input logic [2:0] x_err, input logic [31:0] x_addr,
                         input int x_lat, input int x_strobe, input bit push, input bit b2b);
        exp_t e;
        bit   ok;
        req_is_store = st;
        req_funct3   = f3;
        req_base     = base;
        req_offset   = off;
        req_wdata    = wd;
        req_valid    = 1'b1;
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            @(posedge clk);
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) begin
            checks++;
            $display("FAIL %s_accept: no accept within 64 cycles", name);
        end else begin
            if (b2b) chk({name, "_b2b_accept"}, 32'(acc_cyc), 32'(last_resp_cyc + 1));
            if (push) begin
                e.name = name; e.rdata = x_rdata; e.err = x_err; e.addr = x_addr;
                e.lat = x_lat; e.strobe = x_strobe; e.ftype = f3; e.acc = acc_cyc;
                sb_q.push_back(e);
            end
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) @(posedge clk);
        chk("drain_queue_empty", 32'(sb_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        req_is_store = 1'b0;
        req_funct3 = 3'd0;
        req_base = 32'd0;
        req_offset = 32'd0;
        req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_mem_read_en", 32'(mem_read_en), 32'd0);
        chk("reset_mem_write_en", 32'(mem_write_en), 32'd0);
        chk("reset_ram_address", ram_address, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Normal loads and stores
        issue("lw_104", 1'b0, 3'b010, 32'h100, 32'h4, 32'd0, 32'hDEADBEEF, 3'd0, 32'h104, 3, 1, 1'b1, 1'b0);
        issue("sb_203", 1'b1, 3'b000, 32'h200, 32'h3, 32'h000000A5, 32'd0, 3'd0, 32'h203, 3, 2, 1'b1, 1'b0);
        issue("lbu_203", 1'b0, 3'b100, 32'h203, 32'h0, 32'd0, 32'h000000A5, 3'd0, 32'h203, 3, 1, 1'b1, 1'b0);
        issue("lb_203", 1'b0, 3'b000, 32'h203, 32'h0, 32'd0, 32'hFFFFFFA5, 3'd0, 32'h203, 3, 1, 1'b1, 1'b0);
        issue("lh_106", 1'b0, 3'b001, 32'h100, 32'h6, 32'd0, 32'hFFFFDEAD, 3'd0, 32'h106, 3, 1, 1'b1, 1'b0);
        issue("lhu_106", 1'b0, 3'b101, 32'h106, 32'h0, 32'd0, 32'h0000DEAD, 3'd0, 32'h106, 3, 1, 1'b1, 1'b0);

        // Error cases: no strobe, response one cycle after accept
        issue("lh_mis", 1'b0, 3'b001, 32'h100, 32'h1, 32'd0, 32'd0, 3'd1, 32'h101, 1, 0, 1'b1, 1'b0);
        issue("sw_mis", 1'b1, 3'b010, 32'h102, 32'h0, 32'h12345678, 32'd0, 3'd1, 32'h102, 1, 0, 1'b1, 1'b0);
        issue("lw_range", 1'b0, 3'b010, 32'h1000, 32'h0, 32'd0, 32'd0, 3'd2, 32'h1000, 1, 0, 1'b1, 1'b0);
        issue("lw_wrap", 1'b0, 3'b010, 32'hFFFFFFFC, 32'h8, 32'd0, 32'h11223344, 3'd0, 32'h4, 3, 1, 1'b1, 1'b0);
        issue("ld_ill", 1'b0, 3'b011, 32'h100, 32'h0, 32'd0, 32'd0, 3'd3, 32'h100, 1, 0, 1'b1, 1'b0);
        issue("ld_ill_prio", 1'b0, 3'b111, 32'h1001, 32'h0, 32'd0, 32'd0, 3'd3, 32'h1001, 1, 0, 1'b1, 1'b0);
        issue("st_ill", 1'b1, 3'b011, 32'h100, 32'h0, 32'd0, 32'd0, 3'd3, 32'h100, 1, 0, 1'b1, 1'b0);
        issue("lh_mis_prio", 1'b0, 3'b001, 32'h1001, 32'h0, 32'd0, 32'd0, 3'd1, 32'h1001, 1, 0, 1'b1, 1'b0);
        drain();

        // Silent memory: timeout after 8 WAIT cycles
        mem_dead = 1'b1;
        issue("lw_timeout", 1'b0, 3'b010, 32'h100, 32'h0, 32'd0, 32'd0, 3'd4, 32'h100, 10, 1, 1'b1, 1'b0);
        drain();

        // Reset while waiting abandons the request without a response
        issue("lw_abandon", 1'b0, 3'b010, 32'h100, 32'h0, 32'd0, 32'd0, 3'd0, 32'h100, 0, 0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("midreset_req_ready", 32'(req_ready), 32'd1);
        chk("midreset_resp_valid", 32'(resp_valid), 32'd0);
        chk("midreset_mem_read_en", 32'(mem_read_en), 32'd0);
        mem_dead = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);

        // Back-to-back requests with req_valid held high
        issue("b2b_0", 1'b0, 3'b010, 32'h104, 32'h0, 32'd0, 32'hDEADBEEF, 3'd0, 32'h104, 3, 1, 1'b1, 1'b0);
        issue("b2b_1", 1'b0, 3'b010, 32'h4, 32'h0, 32'd0, 32'h11223344, 3'd0, 32'h4, 3, 1, 1'b1, 1'b1);
        issue("b2b_2", 1'b0, 3'b101, 32'h106, 32'h0, 32'd0, 32'h0000DEAD, 3'd0, 32'h106, 3, 1, 1'b1, 1'b1);
        issue("b2b_3", 1'b0, 3'b001, 32'h101, 32'h0, 32'd0, 32'd0, 3'd1, 32'h101, 1, 0, 1'b1, 1'b1);
        drain();

        repeat (4) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
